// File: rtl/axi4_bram_pkg.sv
// Shared AXI4 encodings and FSM state types for the block-RAM responder.
package axi4_bram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // WRAP and the reserved encoding still run their beats but are answered with SLVERR.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next word address of a burst: INCR steps one word modulo memory size, all else holds.
module axi_burst_addr
  import axi4_bram_pkg::*;
#(
  parameter int WORD_AW = 10
)(
  input  logic [WORD_AW-1:0] addr,
  input  logic [1:0]         burst,
  output logic [WORD_AW-1:0] next_addr
);

  // The word address is exactly WORD_AW bits wide, so the increment wraps at the top of memory.
  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_INCR:  next_addr = addr + {{(WORD_AW-1){1'b0}}, 1'b1};
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = addr;
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_bram_responder.sv
// AXI4 full-width burst responder: independent read and write FSMs sharing one
// simple-dual-port block RAM, read-first when both touch the same word.
module axi4_bram_responder
  import axi4_bram_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int WORD_AW = ADDR_W - OFF_W;
  localparam int WORDS   = 1 << WORD_AW;

  logic [DATA_W-1:0]  mem_r [0:WORDS-1];

  wr_state_e          wr_state_r;
  logic               awready_r, wready_r, bvalid_r, werr_r;
  logic [1:0]         bresp_r, wburst_r;
  logic [ID_W-1:0]    bid_r;
  logic [WORD_AW-1:0] waddr_r, wnext_s;
  logic [7:0]         wlen_r, wcnt_r;
  logic               wbeat_s, wfinal_s, wlast_err_s, mem_we_s;

  rd_state_e          rd_state_r;
  logic               arready_r, rvalid_r, rlast_r, rissued_r;
  logic [1:0]         rresp_r, rburst_r;
  logic [ID_W-1:0]    rid_r;
  logic [WORD_AW-1:0] raddr_r, rnext_s;
  logic [7:0]         rlen_r, rcnt_r;
  logic [DATA_W-1:0]  rdata_r;
  logic               mem_re_s;

  // Sub-word address bits are ignored: every transfer is full bus width.
  logic unused_s;
  assign unused_s = ^{s_axi_awaddr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

  axi_burst_addr #(.WORD_AW(WORD_AW)) u_waddr (.addr(waddr_r), .burst(wburst_r), .next_addr(wnext_s));
  axi_burst_addr #(.WORD_AW(WORD_AW)) u_raddr (.addr(raddr_r), .burst(rburst_r), .next_addr(rnext_s));

  assign wbeat_s     = (wr_state_r == W_DATA) && wready_r && s_axi_wvalid;
  assign wfinal_s    = (wcnt_r == wlen_r);
  assign wlast_err_s = (s_axi_wlast != wfinal_s);
  assign mem_we_s    = wbeat_s && burst_ok(wburst_r);
  assign mem_re_s    = (rd_state_r == R_DATA) && !rissued_r && (!rvalid_r || s_axi_rready);

  // Write FSM: address latch, beat counting against awlen, then one B response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      bid_r      <= {ID_W{1'b0}};
      waddr_r    <= {WORD_AW{1'b0}};
      wlen_r     <= 8'd0;
      wcnt_r     <= 8'd0;
      wburst_r   <= BURST_INCR;
      werr_r     <= 1'b0;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (s_axi_awvalid && awready_r) begin
            awready_r  <= 1'b0;
            wready_r   <= 1'b1;
            bid_r      <= s_axi_awid;
            waddr_r    <= s_axi_awaddr[ADDR_W-1:OFF_W];
            wlen_r     <= s_axi_awlen;
            wburst_r   <= s_axi_awburst;
            wcnt_r     <= 8'd0;
            werr_r     <= !burst_ok(s_axi_awburst);
            wr_state_r <= W_DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_DATA: begin
          if (wbeat_s) begin
            waddr_r <= wnext_s;
            wcnt_r  <= wcnt_r + 8'd1;
            if (wfinal_s) begin
              wready_r   <= 1'b0;
              bvalid_r   <= 1'b1;
              bresp_r    <= (werr_r || wlast_err_s) ? RESP_SLVERR : RESP_OKAY;
              wr_state_r <= W_RESP;
            end else if (wlast_err_s) begin
              werr_r <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wr_state_r <= W_IDLE;
          end
        end
        default: begin
          wr_state_r <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: issue a RAM read whenever the output register is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rlast_r    <= 1'b0;
      rresp_r    <= RESP_OKAY;
      rid_r      <= {ID_W{1'b0}};
      raddr_r    <= {WORD_AW{1'b0}};
      rlen_r     <= 8'd0;
      rcnt_r     <= 8'd0;
      rburst_r   <= BURST_INCR;
      rissued_r  <= 1'b0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (s_axi_arvalid && arready_r) begin
            arready_r  <= 1'b0;
            rid_r      <= s_axi_arid;
            raddr_r    <= s_axi_araddr[ADDR_W-1:OFF_W];
            rlen_r     <= s_axi_arlen;
            rburst_r   <= s_axi_arburst;
            rresp_r    <= burst_ok(s_axi_arburst) ? RESP_OKAY : RESP_SLVERR;
            rcnt_r     <= 8'd0;
            rissued_r  <= 1'b0;
            rd_state_r <= R_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (mem_re_s) begin
            rvalid_r <= 1'b1;
            rlast_r  <= (rcnt_r == rlen_r);
            raddr_r  <= rnext_s;
            rcnt_r   <= rcnt_r + 8'd1;
            if (rcnt_r == rlen_r) begin
              rissued_r <= 1'b1;
            end
          end else if (rvalid_r && s_axi_rready) begin
            rvalid_r <= 1'b0;
            if (rlast_r) begin
              rlast_r    <= 1'b0;
              arready_r  <= 1'b1;
              rd_state_r <= R_IDLE;
            end
          end
        end
        default: begin
          rd_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Byte-enabled write port; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) begin
          mem_r[waddr_r][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Clock-enabled output register doubles as the R data holding stage under backpressure.
  always_ff @(posedge clk) begin
    if (mem_re_s) begin
      rdata_r <= mem_r[raddr_r];
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_bid     = bid_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rlast   = rlast_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rid     = rid_r;
  assign s_axi_rdata   = rdata_r;

endmodule

// File: tb/tb_axi4_bram_responder.sv
`timescale 1ns/1ps
// Bench for axi4_bram_responder: bursts checked against a byte-array memory model
// through expectation queues drained by an independent negedge monitor.
module tb_axi4_bram_responder;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 16;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;
  localparam int WORDS  = (1 << ADDR_W) / STRB_W;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ID_W-1:0]   s_axi_awid = '0;
  logic [ADDR_W-1:0] s_axi_awaddr = '0;
  logic [7:0]        s_axi_awlen = '0;
  logic [1:0]        s_axi_awburst = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata = '0;
  logic [STRB_W-1:0] s_axi_wstrb = '0;
  logic              s_axi_wlast = 1'b0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b0;
  logic [ID_W-1:0]   s_axi_arid = '0;
  logic [ADDR_W-1:0] s_axi_araddr = '0;
  logic [7:0]        s_axi_arlen = '0;
  logic [1:0]        s_axi_arburst = '0;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b0;

  axi4_bram_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DATA_W-1:0] data; logic last; logic [1:0] resp; logic [ID_W-1:0] id; } rexp_t;
  typedef struct { logic [1:0] resp; logic [ID_W-1:0] id; } bexp_t;

  rexp_t exp_r[$];
  bexp_t exp_b[$];
  logic [7:0] mem_m [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] wd [0:15];
  logic [STRB_W-1:0] ws [0:15];
  int n_tests = 0;
  int n_fail  = 0;
  int r_pops  = 0;
  bit rr_rand = 1'b0;
  bit br_rand = 1'b0;
  bit stall_v = 1'b0;
  logic [DATA_W-1:0] stall_d;
  logic stall_l;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic int word_of(input logic [ADDR_W-1:0] addr, input logic [1:0] burst, input int beat);
    int start;
    start = int'(addr) / STRB_W;
    if (burst == INCR) return (start + beat) % WORDS;
    return start;
  endfunction

  function automatic logic [DATA_W-1:0] model_word(input int w);
    logic [DATA_W-1:0] v;
    for (int b = 0; b < STRB_W; b++) v[b*8 +: 8] = mem_m[w*STRB_W + b];
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] region(input int r);
    return ADDR_W'(32'h2000 + r * 32'h0200);
  endfunction

  task automatic fill_random(input int n, input bit rand_strb);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < DATA_W/32; j++) wd[i][j*32 +: 32] = $urandom;
      ws[i] = rand_strb ? {$urandom, $urandom} : {STRB_W{1'b1}};
    end
  endtask

  task automatic push_read_exp(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len, input logic [1:0] burst);
    rexp_t e;
    for (int i = 0; i <= len; i++) begin
      e.data = model_word(word_of(addr, burst, i));
      e.last = (i == len);
      e.resp = (burst == FIXED || burst == INCR) ? 2'b00 : 2'b10;
      e.id   = id;
      exp_r.push_back(e);
    end
  endtask

  task automatic drive_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len, input logic [1:0] burst);
    bit got = 1'b0;
    @(posedge clk); #1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_axi_arready) begin got = 1'b1; break; end
    end
    if (!got) fail_now("ar_handshake");
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len, input logic [1:0] burst);
    push_read_exp(id, addr, len, burst);
    drive_ar(id, addr, len, burst);
  endtask

  // bad_beat >= 0 flips wlast on that beat (early on a non-final beat, missing on the final one).
  task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len,
                          input logic [1:0] burst, input int bad_beat, input bit gaps);
    bexp_t e;
    bit ok;
    bit got;
    ok = (burst == FIXED || burst == INCR);
    e.resp = (ok && bad_beat < 0) ? 2'b00 : 2'b10;
    e.id = id;
    exp_b.push_back(e);
    if (ok) begin
      for (int i = 0; i <= len; i++)
        for (int b = 0; b < STRB_W; b++)
          if (ws[i][b]) mem_m[word_of(addr, burst, i)*STRB_W + b] = wd[i][b*8 +: 8];
    end
    @(posedge clk); #1;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_axi_awready) begin got = 1'b1; break; end
    end
    if (!got) fail_now("aw_handshake");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
      s_axi_wlast = (i == len) != (i == bad_beat);
      s_axi_wvalid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (s_axi_wready) begin got = 1'b1; break; end
      end
      if (!got) fail_now("w_handshake");
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      if (exp_r.size() == 0 && exp_b.size() == 0) break;
      @(negedge clk);
    end
    if (exp_r.size() != 0 || exp_b.size() != 0) begin
      fail_now("responses_outstanding");
      exp_r.delete();
      exp_b.delete();
    end
  endtask

  // Ready generators: steady high, or random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    s_axi_rready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    s_axi_bready = br_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: every handshake seen before the next rising edge is popped and compared.
  always @(negedge clk) begin
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        check("r_stall_valid", s_axi_rvalid, 1'b1);
        check("r_stall_data", s_axi_rdata, stall_d);
        check("r_stall_last", s_axi_rlast, stall_l);
      end
      stall_v = s_axi_rvalid && !s_axi_rready;
      stall_d = s_axi_rdata;
      stall_l = s_axi_rlast;
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected_beat", s_axi_rvalid, 1'b0);
        end else begin
          rexp_t e;
          e = exp_r.pop_front();
          r_pops++;
          check("r_data", s_axi_rdata, e.data);
          check("r_last_resp_id", {s_axi_rlast, s_axi_rresp, s_axi_rid}, {e.last, e.resp, e.id});
        end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", s_axi_bvalid, 1'b0);
        end else begin
          bexp_t e;
          e = exp_b.pop_front();
          check("b_resp_id", {s_axi_bresp, s_axi_bid}, {e.resp, e.id});
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int target;
    for (int i = 0; i < (1 << ADDR_W); i++) mem_m[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_wready", s_axi_wready, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_rlast", s_axi_rlast, 1'b0);
    check("rst_resp", {s_axi_bresp, s_axi_rresp}, 4'h0);
    check("rst_ids", {s_axi_bid, s_axi_rid}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("awready_after_rst", s_axi_awready, 1'b1);
    check("arready_after_rst", s_axi_arready, 1'b1);

    // INCR write/read of four beats plus first-beat latency.
    for (int i = 0; i < 4; i++) begin wd[i] = DATA_W'(32'hA0 + i); ws[i] = {STRB_W{1'b1}}; end
    do_write(4'h1, 16'h0100, 3, INCR, -1, 1'b0);
    wait_idle();
    push_read_exp(4'h2, 16'h0100, 3, INCR);
    drive_ar(4'h2, 16'h0100, 3, INCR);
    @(negedge clk);
    check("rvalid_at_ar_plus1", s_axi_rvalid, 1'b0);
    @(negedge clk);
    check("rvalid_at_ar_plus2", s_axi_rvalid, 1'b1);
    wait_idle();

    // FIXED burst keeps only the final beat, then a single-byte strobe overwrite.
    for (int i = 0; i < 3; i++) begin wd[i] = DATA_W'(i + 1); ws[i] = {STRB_W{1'b1}}; end
    do_write(4'h3, 16'h0200, 2, FIXED, -1, 1'b0);
    wait_idle();
    do_read(4'h4, 16'h0200, 0, FIXED);
    wait_idle();
    wd[0] = {DATA_W{1'b1}}; ws[0] = STRB_W'(1);
    do_write(4'h5, 16'h0200, 0, FIXED, -1, 1'b0);
    wait_idle();
    do_read(4'h4, 16'h0200, 0, INCR);
    wait_idle();

    // INCR burst across the top of memory wraps to word 0.
    fill_random(2, 1'b0);
    do_write(4'h6, 16'hFFC0, 1, INCR, -1, 1'b0);
    wait_idle();
    do_read(4'h7, 16'hFFC0, 1, INCR);
    do_read(4'h8, 16'h0000, 0, INCR);
    wait_idle();

    // Unsupported bursts: writes suppressed, reads repeat the start word, both SLVERR.
    fill_random(2, 1'b0);
    do_write(4'h9, 16'h0300, 1, INCR, -1, 1'b0);
    wait_idle();
    fill_random(2, 1'b0);
    do_write(4'hA, 16'h0300, 1, RSVD, -1, 1'b0);
    wait_idle();
    do_write(4'hA, 16'h0300, 1, WRAP, -1, 1'b1);
    wait_idle();
    do_read(4'hB, 16'h0300, 1, INCR);
    do_read(4'hC, 16'h0300, 1, WRAP);
    wait_idle();

    // wlast mismatches: early on beat 0, and missing on the final beat.
    fill_random(3, 1'b0);
    do_write(4'hD, 16'h0400, 2, INCR, 0, 1'b0);
    wait_idle();
    do_read(4'hE, 16'h0400, 2, INCR);
    wait_idle();
    fill_random(2, 1'b0);
    do_write(4'hD, 16'h0500, 1, INCR, 1, 1'b0);
    wait_idle();
    do_read(4'hE, 16'h0500, 1, INCR);
    wait_idle();

    // Same-word read and write committed in the same cycle: read sees the old word.
    fill_random(1, 1'b0);
    do_write(4'h1, 16'h0600, 0, FIXED, -1, 1'b0);
    wait_idle();
    push_read_exp(4'h2, 16'h0600, 0, FIXED);
    fill_random(1, 1'b0);
    fork
      drive_ar(4'h2, 16'h0600, 0, FIXED);
      do_write(4'h3, 16'h0600, 0, FIXED, -1, 1'b0);
    join
    wait_idle();
    do_read(4'h4, 16'h0600, 0, FIXED);
    wait_idle();

    // Concurrent 8-beat bursts with random backpressure, W gaps and partial strobes.
    for (int r = 0; r < 5; r++) begin
      fill_random(8, 1'b0);
      do_write(4'(r), region(r), 7, INCR, -1, 1'b1);
      wait_idle();
    end
    rr_rand = 1'b1;
    br_rand = 1'b1;
    for (int r = 1; r < 5; r++) begin
      logic [ID_W-1:0] rid;
      rid = 4'($urandom);
      fill_random(8, 1'b1);
      push_read_exp(rid, region(r - 1), 7, INCR);
      fork
        drive_ar(rid, region(r - 1), 7, INCR);
        do_write(4'($urandom), region(r), 7, INCR, -1, 1'b1);
      join
      wait_idle();
    end
    do_read(4'h5, region(4), 7, INCR);
    wait_idle();
    rr_rand = 1'b0;
    br_rand = 1'b0;

    // Reset during beat 2 of an 8-beat read, then a clean read afterwards.
    target = r_pops + 2;
    do_read(4'h6, region(1), 7, INCR);
    for (int k = 0; k < 200; k++) begin
      if (r_pops >= target) break;
      @(negedge clk);
    end
    if (r_pops < target) fail_now("mid_burst_beats");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_r.delete();
    @(negedge clk);
    check("midrst_rvalid", s_axi_rvalid, 1'b0);
    check("midrst_arready", s_axi_arready, 1'b0);
    check("midrst_rlast", s_axi_rlast, 1'b0);
    @(negedge clk);
    check("midrst_arready_rise", s_axi_arready, 1'b1);
    do_read(4'h7, region(2), 7, INCR);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_bram_responder.md
# axi4_bram_responder

AXI4 memory-mapped responder (slave) backed by on-chip block RAM, the far end of the XDMA AXI master port in the PCIe/DDR4 platform. It accepts host-initiated INCR/FIXED bursts on independent read and write channels and serves them from a single inferred simple-dual-port RAM. It is a low-latency scratch/descriptor memory beside the DDR4 controllers, and a known-good AXI target for bring-up of the XDMA data path.

## Interface
- DATA_W, 512, data bus width in bits; power of two, ≥32
- ADDR_W, 16, byte-address width; memory holds 2^ADDR_W bytes = 2^(ADDR_W−log2(DATA_W/8)) words
- ID_W, 4, AXI ID width
- clk  in  1  sole clock; all ports synchronous to it
- rst  in  1  reset; synchronous, active-high
- s_axi_awid / awaddr / awlen / awburst / awvalid  in  ID_W / ADDR_W / 8 / 2 / 1  write address channel
- s_axi_awready  out  1  write address accept
- s_axi_wdata / wstrb / wlast / wvalid  in  DATA_W / DATA_W/8 / 1 / 1  write data channel
- s_axi_wready  out  1  write data accept
- s_axi_bid / bresp / bvalid  out  ID_W / 2 / 1  write response
- s_axi_bready  in  1  write response accept
- s_axi_arid / araddr / arlen / arburst / arvalid  in  ID_W / ADDR_W / 8 / 2 / 1  read address channel
- s_axi_arready  out  1  read address accept
- s_axi_rid / rdata / rresp / rlast / rvalid  out  ID_W / DATA_W / 2 / 1 / 1  read data channel
- s_axi_rready  in  1  read data accept

## Operation
- Size is always full bus width; low log2(DATA_W/8) address bits ignored (aligned). Address bits above ADDR_W do not exist; word address wraps modulo memory size.
- Write FSM: W_IDLE → (awvalid&awready) latch id/addr/len/burst, beat count=0 → W_DATA → each wvalid&wready writes wdata under wstrb, advances address, count++ → beat count==awlen → W_RESP → bvalid until bready → W_IDLE.
- Read FSM: R_IDLE → (arvalid&arready) latch → R_DATA: issue RAM read whenever !rvalid || rready; advance address, count++; rlast set on beat arlen; after last beat handshake → R_IDLE.
- Address step: INCR +1 word per beat, wrapping at end of memory to word 0; FIXED repeats same word.
- awburst/arburst = WRAP (2'b10) or reserved (2'b11): burst still runs the full len+1 beats (W consumed, R returns data of the start word each beat), writes suppressed, resp SLVERR.
- wlast check: beat count is authoritative; wlast high on a non-final beat, or low on the final beat, → bresp SLVERR; data still written.
- Otherwise resp OKAY (2'b00); SLVERR = 2'b10. bid/rid echo latched IDs.
- Read and write channels fully independent; same-word read and write in same cycle → read returns old data (read-first).
- No outstanding transactions beyond one per direction.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=rresp=0, bid=rid=0; awready/arready rise the first cycle after rst deasserts. RAM contents not reset.
- Write: AW handshake cycle T → wready high T+1 onward; last W beat at U → bvalid at U+1; B handshake at V → awready high V+1.
- Read: AR handshake T → first RAM read T+1 → rvalid T+2; sustains 1 beat/cycle with rready high; rready low holds rdata/rlast stable (RAM output register clock-enabled). Last R handshake at V → arready high V+1.
- rst mid-burst: next cycle all valid/ready outputs at reset values, both FSMs idle, partial write beats already committed remain.

## Structure
- Package axi4_bram_pkg: burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR), write and read FSM state enums.
- Sub-module axi_burst_addr: combinational next-word-address from current address and burst type with wrap modulo memory size; instantiated once per channel.
- RAM: inferred simple-dual-port, one write port with byte enables, one read port with output register and clock enable.

## Test plan
- INCR write awaddr=0x0100, awlen=3, data 0xA0..0xA3 full strobes, then INCR read same → rdata 0xA0..0xA3, rlast on beat 3, bresp=rresp=OKAY, rvalid at AR+2.
- FIXED write awlen=2 to 0x0200 data 1,2,3 then read len=0 → rdata 3; strobe test wstrb=0x...01 writes byte 0 only.
- INCR write starting at last word 0xFFC0, awlen=1 → second beat lands at word 0; read back confirms.
- awburst=2'b11 awlen=1 → 2 W beats accepted, memory unchanged, bresp=SLVERR; early wlast on beat 0 of len 2 → SLVERR, all 3 beats written.
- Random rready/bready backpressure and wvalid gaps over 8-beat bursts with concurrent read/write to same word → read-first data, no beat lost or duplicated, rdata stable while stalled.
- Assert rst mid-read burst beat 2 of 8 → next cycle rvalid=0, arready=0 then 1; new read completes correctly.
